// File: rtl/decrypt_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_frame_ctrl
// Description : Byte-stream front end for a combinational decrypt core.
//               Parses frames of the form SYNC, KEY, LEN, LEN data bytes, CHK
//               from a valid/ready RX byte stream. Drives the core's key and
//               ciphertext inputs from registers. Captures the core output one
//               cycle later into a small plaintext FIFO with a valid/ready
//               output side.
// Ports       : clk, rst_n                - clock, async active-low reset
//               rx_valid_i/rx_data_i/rx_ready_o - incoming frame bytes
//               dec_key_o/dec_inp_o       - registered key / ciphertext to core
//               dec_out_i                 - plaintext from core (combinational)
//               pt_valid_o/pt_data_o/pt_last_o/pt_ready_i - plaintext FIFO head
//               frame_done_o/frame_err_o  - 1-cycle frame status pulses
//               busy_o                    - frame in progress or capture pending
// Revision    : 1.0 - initial release
// ============================================================================
module decrypt_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         MAX_LEN    = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_ready_o,
    output logic [7:0] dec_key_o,
    output logic [7:0] dec_inp_o,
    input  logic [7:0] dec_out_i,
    output logic       pt_valid_o,
    output logic [7:0] pt_data_o,
    output logic       pt_last_o,
    input  logic       pt_ready_i,
    output logic       frame_done_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      key_q, key_d;
    logic [7:0]      inp_q, inp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      chk_q, chk_d;
    logic            cap_q, cap_d;
    logic            cap_last_q, cap_last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;

    logic            accept;
    logic            len_ok;
    logic            push, pop;
    logic [AW+1:0]   occupancy;

    // Occupancy includes the byte still in the capture stage, so a DATA byte
    // is only accepted when the FIFO is guaranteed a free slot for it.
    assign occupancy  = {1'b0, count_q} + {{(AW + 1){1'b0}}, cap_q};
    assign rx_ready_o = (state_q != ST_DATA) || (occupancy < (AW + 2)'(FIFO_DEPTH));
    assign accept     = rx_valid_i && rx_ready_o;
    assign len_ok     = (rx_data_i != 8'd0) && (int'({24'd0, rx_data_i}) <= MAX_LEN);

    assign push       = cap_q;
    assign pop        = pt_valid_o && pt_ready_i;

    assign dec_key_o    = key_q;
    assign dec_inp_o    = inp_q;
    assign pt_valid_o   = (count_q != '0);
    assign pt_data_o    = pt_valid_o ? mem_q[rd_ptr_q][7:0] : 8'd0;
    assign pt_last_o    = pt_valid_o ? mem_q[rd_ptr_q][8]   : 1'b0;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;
    assign busy_o       = (state_q != ST_IDLE) || cap_q;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        inp_d      = inp_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        cap_d      = 1'b0;
        cap_last_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data_i == SYNC_BYTE) state_d = ST_KEY;
                end
                ST_KEY: begin
                    key_d   = rx_data_i;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (len_ok) begin
                        cnt_d   = CW'(rx_data_i);
                        chk_d   = 8'd0;
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    inp_d      = rx_data_i;
                    chk_d      = chk_q ^ rx_data_i;
                    cnt_d      = cnt_q - CW'(1);
                    cap_d      = 1'b1;
                    cap_last_d = (cnt_q == CW'(1));
                    if (cnt_q == CW'(1)) state_d = ST_CHK;
                end
                ST_CHK: begin
                    done_d  = (rx_data_i == chk_q);
                    err_d   = (rx_data_i != chk_q);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            key_q      <= 8'd0;
            inp_q      <= 8'd0;
            cnt_q      <= '0;
            chk_q      <= 8'd0;
            cap_q      <= 1'b0;
            cap_last_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            inp_q      <= inp_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            cap_q      <= cap_d;
            cap_last_q <= cap_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cap_last_q, dec_out_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decrypt_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decrypt_frame_ctrl
// Description : Directed self-checking bench for decrypt_frame_ctrl. Supplies
//               a stand-in decrypt core and checks frame parsing, capture
//               latency, backpressure, FIFO ordering and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decrypt_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] dec_key, dec_inp, dec_out;
    logic       pt_valid, pt_last, pt_ready;
    logic [7:0] pt_data;
    logic       frame_done, frame_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done, n_err, n_both;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    // Stand-in for the combinational decrypt core.
    function automatic logic [7:0] gd(input logic [7:0] k, input logic [7:0] c);
        logic [7:0] x;
        x = c ^ k;
        return {x[4:0], x[7:5]} ^ (k + 8'h1B);
    endfunction

    assign dec_out = gd(dec_key, dec_inp);

    decrypt_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready),
        .dec_key_o    (dec_key),
        .dec_inp_o    (dec_inp),
        .dec_out_i    (dec_out),
        .pt_valid_o   (pt_valid),
        .pt_data_o    (pt_data),
        .pt_last_o    (pt_last),
        .pt_ready_i   (pt_ready),
        .frame_done_o (frame_done),
        .frame_err_o  (frame_err),
        .busy_o       (busy)
    );

    // Inputs change 1ns after a rising edge, so the falling edge sees stable
    // handshakes: a head seen with valid&ready here is popped at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pt_valid && pt_ready) got.push_back({pt_last, pt_data});
            if (frame_done) n_done++;
            if (frame_err)  n_err++;
            if (frame_done && frame_err) n_both++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_obs();
        got.delete(); exp_q.delete();
        n_done = 0; n_err = 0;
    endtask

    // Returns 1ns after the edge at which the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && k < 60) begin @(posedge clk); #1; k++; end
        if (!rx_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte_timeout: byte %02h not accepted in 60 cycles", b);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] key, input int len, input logic [7:0] base);
        logic [7:0] c, d;
        c = 8'd0;
        send_byte(8'hA5); send_byte(key); send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            d = base + 8'(i * 8'h13);
            c = c ^ d;
            exp_q.push_back({(i == len - 1), gd(key, d)});
            send_byte(d);
        end
        send_byte(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; pt_ready = 1'b0;
        n_both = 0;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({pt_valid, pt_data, pt_last} !== 10'd0) begin n_bad++;
            $display("FAIL reset_pt: got %0b/%02h/%0b want 0/00/0", pt_valid, pt_data, pt_last); end
        n_cmp++; if ({frame_done, frame_err, busy} !== 3'b000) begin n_bad++;
            $display("FAIL reset_flags: done/err/busy got %03b want 000", {frame_done, frame_err, busy}); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_rx_ready: got %0b want 1", rx_ready); end
        n_cmp++; if ({dec_key, dec_inp} !== 16'd0) begin n_bad++;
            $display("FAIL reset_dec: key/inp got %02h/%02h want 00/00", dec_key, dec_inp); end
        rst_n = 1'b1;
        idle(2);
        // Non-SYNC bytes in IDLE are dropped without any error.
        send_byte(8'h3C); send_byte(8'h00);
        idle(2);
        n_cmp++; if (n_err !== 0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL idle_drop: err=%0d busy=%0b want 0/0", n_err, busy); end
    endtask

    task automatic test_happy();
        clear_obs();
        pt_ready = 1'b1;
        send_byte(8'hA5);
        n_cmp++; if (busy !== 1'b1) begin n_bad++;
            $display("FAIL happy_busy: got %0b want 1", busy); end
        send_byte(8'h5A); send_byte(8'h02);
        send_byte(8'h3C);
        n_cmp++; if (dec_inp !== 8'h3C || dec_key !== 8'h5A || pt_valid !== 1'b0) begin n_bad++;
            $display("FAIL happy_stage1: key=%02h inp=%02h valid=%0b want 5a/3c/0", dec_key, dec_inp, pt_valid); end
        send_byte(8'hC3);
        n_cmp++; if (pt_valid !== 1'b1 || pt_data !== gd(8'h5A, 8'h3C) || pt_last !== 1'b0) begin n_bad++;
            $display("FAIL happy_latency: valid=%0b data=%02h last=%0b want 1/%02h/0", pt_valid, pt_data, pt_last, gd(8'h5A, 8'h3C)); end
        send_byte(8'hFF);
        n_cmp++; if (frame_done !== 1'b1 || frame_err !== 1'b0) begin n_bad++;
            $display("FAIL happy_done_pulse: done=%0b err=%0b want 1/0", frame_done, frame_err); end
        idle(4);
        n_cmp++; if (got.size() !== 2) begin n_bad++;
            $display("FAIL happy_count: got %0d entries want 2", got.size()); end
        else begin
            n_cmp++; if (got[0] !== {1'b0, gd(8'h5A, 8'h3C)} || got[1] !== {1'b1, gd(8'h5A, 8'hC3)}) begin n_bad++;
                $display("FAIL happy_data: got %03h %03h want %03h %03h", got[0], got[1], {1'b0, gd(8'h5A, 8'h3C)}, {1'b1, gd(8'h5A, 8'hC3)}); end
        end
        n_cmp++; if (n_done !== 1 || n_err !== 0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL happy_status: done=%0d err=%0d busy=%0b want 1/0/0", n_done, n_err, busy); end
    endtask

    task automatic test_bad_len();
        clear_obs();
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h00);
        n_cmp++; if (frame_err !== 1'b1 || frame_done !== 1'b0) begin n_bad++;
            $display("FAIL badlen_pulse_timing: err=%0b done=%0b want 1/0", frame_err, frame_done); end
        idle(2);
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h11);
        idle(3);
        n_cmp++; if (n_err !== 2 || n_done !== 0) begin n_bad++;
            $display("FAIL badlen_count: err=%0d done=%0d want 2/0", n_err, n_done); end
        n_cmp++; if (pt_valid !== 1'b0 || got.size() !== 0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL badlen_idle: valid=%0b entries=%0d busy=%0b want 0/0/0", pt_valid, got.size(), busy); end
    endtask

    task automatic test_chk_fail();
        clear_obs();
        pt_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h22); send_byte(8'h01); send_byte(8'hA5); send_byte(8'h00);
        idle(4);
        n_cmp++; if (got.size() !== 1 || got[0] !== {1'b1, gd(8'h22, 8'hA5)}) begin n_bad++;
            $display("FAIL chkfail_data: entries=%0d head=%03h want 1/%03h", got.size(), (got.size() > 0) ? got[0] : 9'h0, {1'b1, gd(8'h22, 8'hA5)}); end
        n_cmp++; if (n_err !== 1 || n_done !== 0) begin n_bad++;
            $display("FAIL chkfail_status: err=%0d done=%0d want 1/0", n_err, n_done); end
    endtask

    task automatic test_backpressure();
        clear_obs();
        pt_ready = 1'b0;
        fork
            send_frame(8'h77, 8, 8'h05);
            begin
                idle(14);
                n_cmp++; if (rx_ready !== 1'b0 || busy !== 1'b1) begin n_bad++;
                    $display("FAIL bp_stall: rx_ready=%0b busy=%0b want 0/1", rx_ready, busy); end
                n_cmp++; if (pt_valid !== 1'b1 || pt_data !== gd(8'h77, 8'h05) || got.size() !== 0) begin n_bad++;
                    $display("FAIL bp_head_hold: valid=%0b data=%02h popped=%0d want 1/%02h/0", pt_valid, pt_data, got.size(), gd(8'h77, 8'h05)); end
                pt_ready = 1'b1;
            end
        join
        idle(6);
        n_cmp++; if (got.size() !== 8) begin n_bad++;
            $display("FAIL bp_count: got %0d entries want 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL bp_entry%0d: got %03h want %03h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (n_done !== 1 || n_err !== 0) begin n_bad++;
            $display("FAIL bp_status: done=%0d err=%0d want 1/0", n_done, n_err); end
    endtask

    task automatic test_pushpop_wrap();
        clear_obs();
        pt_ready = 1'b0;
        send_frame(8'h31, 3, 8'h01);
        idle(3);
        send_byte(8'hA5); send_byte(8'h32); send_byte(8'h01); send_byte(8'h04);
        exp_q.push_back({1'b1, gd(8'h32, 8'h04)});
        // Capture is pending with 3 entries queued: pop and push share this edge.
        pt_ready = 1'b1;
        idle(1);
        pt_ready = 1'b0;
        n_cmp++; if (pt_valid !== 1'b1 || pt_data !== exp_q[1][7:0] || got.size() !== 1) begin n_bad++;
            $display("FAIL pp_head: valid=%0b data=%02h popped=%0d want 1/%02h/1", pt_valid, pt_data, got.size(), exp_q[1][7:0]); end
        send_byte(8'h04);
        pt_ready = 1'b1;
        send_frame(8'h40, 2, 8'h50);
        send_frame(8'h41, 3, 8'h60);
        send_frame(8'h42, 1, 8'h70);
        idle(6);
        n_cmp++; if (got.size() !== exp_q.size()) begin n_bad++;
            $display("FAIL pp_count: got %0d entries want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL pp_entry%0d: got %03h want %03h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (n_done !== 5 || n_err !== 0) begin n_bad++;
            $display("FAIL pp_status: done=%0d err=%0d want 5/0", n_done, n_err); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        pt_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h55); send_byte(8'h04); send_byte(8'h10); send_byte(8'h20);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({pt_valid, pt_data, pt_last, busy} !== 11'd0 || rx_ready !== 1'b1) begin n_bad++;
            $display("FAIL rstmid_outputs: valid=%0b data=%02h last=%0b busy=%0b rdy=%0b want 0/00/0/0/1", pt_valid, pt_data, pt_last, busy, rx_ready); end
        n_cmp++; if ({dec_key, dec_inp, frame_done, frame_err} !== 18'd0) begin n_bad++;
            $display("FAIL rstmid_dec: key=%02h inp=%02h done=%0b err=%0b want 0", dec_key, dec_inp, frame_done, frame_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_obs();
        pt_ready = 1'b1;
        send_frame(8'h66, 3, 8'h21);
        idle(5);
        n_cmp++; if (got.size() !== 3) begin n_bad++;
            $display("FAIL rstmid_count: got %0d entries want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_bad++;
                $display("FAIL rstmid_entry%0d: got %03h want %03h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (n_done !== 1 || n_err !== 0 || n_both !== 0) begin n_bad++;
            $display("FAIL rstmid_status: done=%0d err=%0d both=%0d want 1/0/0", n_done, n_err, n_both); end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_bad_len();
        test_chk_fail();
        test_backpressure();
        test_pushpop_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
